// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: sequencer state encoding and drain depth.
package mips_pkg;

    typedef enum logic [2:0] {
        PSEQ_IDLE  = 3'd0,
        PSEQ_RUN   = 3'd1,
        PSEQ_STEP  = 3'd2,
        PSEQ_DRAIN = 3'd3,
        PSEQ_DONE  = 3'd4
    } pseq_state_t;

    localparam int PSEQ_DRAIN_CYCLES = 3;

endpackage

// File: rtl/pipe_seq_counter.sv
// Wrapping cycle counter for the pipeline sequencer; counts while en is high.
module pipe_seq_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipeline_sequencer.sv
// Run/step/halt controller driving PC and stage-register enables and flushes.
// Optional single-step support is compiled in when PIPE_SEQ_STEP_EN is defined.
module pipeline_sequencer
    import mips_pkg::*;
#(
    parameter int DRAIN_CYCLES = PSEQ_DRAIN_CYCLES,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             I_RUN,
    input  logic             I_STEP,
    input  logic             I_HALT_DECODED,
    input  logic             I_LOAD_USE,
    input  logic             I_BRANCH_TAKEN,
    output logic             O_PC_EN,
    output logic             O_IF_ID_EN,
    output logic             O_ID_EX_EN,
    output logic             O_EX_MEM_EN,
    output logic             O_MEM_WB_EN,
    output logic             O_IF_ID_FLUSH,
    output logic             O_ID_EX_FLUSH,
    output logic [2:0]       O_STATE,
    output logic             O_DONE,
    output logic [CNT_W-1:0] O_CYCLE_COUNT
);

    localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

    pseq_state_t   state_reg, state_next;
    logic [DW-1:0] drain_cnt_reg, drain_cnt_next;
    logic          done_reg, done_next;
    logic          advance;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg     <= PSEQ_IDLE;
            drain_cnt_reg <= '0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        done_next      = done_reg;
        advance        = 1'b0;
        O_PC_EN        = 1'b0;
        O_IF_ID_EN     = 1'b0;
        O_ID_EX_EN     = 1'b0;
        O_EX_MEM_EN    = 1'b0;
        O_MEM_WB_EN    = 1'b0;
        O_IF_ID_FLUSH  = 1'b0;
        O_ID_EX_FLUSH  = 1'b0;

        case (state_reg)
            PSEQ_IDLE: begin
                if (I_RUN) begin
                    state_next = PSEQ_RUN;
`ifdef PIPE_SEQ_STEP_EN
                end else if (I_STEP) begin
                    state_next = PSEQ_STEP;
`endif
                end
            end

`ifdef PIPE_SEQ_STEP_EN
            PSEQ_RUN, PSEQ_STEP: begin
`else
            PSEQ_RUN: begin
`endif
                advance     = 1'b1;
                O_PC_EN     = 1'b1;
                O_IF_ID_EN  = 1'b1;
                O_ID_EX_EN  = 1'b1;
                O_EX_MEM_EN = 1'b1;
                O_MEM_WB_EN = 1'b1;
                // A single step falls back to IDLE unless a HALT sends it to DRAIN.
                if (state_reg != PSEQ_RUN) begin
                    state_next = PSEQ_IDLE;
                end
                if (I_BRANCH_TAKEN) begin
                    O_IF_ID_FLUSH = 1'b1;
                    O_ID_EX_FLUSH = 1'b1;
                end else if (I_LOAD_USE) begin
                    O_PC_EN       = 1'b0;
                    O_IF_ID_EN    = 1'b0;
                    O_ID_EX_FLUSH = 1'b1;
                end else if (I_HALT_DECODED) begin
                    state_next     = PSEQ_DRAIN;
                    drain_cnt_next = DW'(DRAIN_CYCLES - 1);
                end
            end

            PSEQ_DRAIN: begin
                advance       = 1'b1;
                O_ID_EX_EN    = 1'b1;
                O_ID_EX_FLUSH = 1'b1;
                O_EX_MEM_EN   = 1'b1;
                O_MEM_WB_EN   = 1'b1;
                if (drain_cnt_reg == '0) begin
                    state_next = PSEQ_DONE;
                    done_next  = 1'b1;
                end else begin
                    drain_cnt_next = drain_cnt_reg - DW'(1);
                end
            end

            PSEQ_DONE: begin
                state_next = PSEQ_DONE;
            end

            default: begin
                state_next = PSEQ_IDLE;
            end
        endcase
    end

`ifndef PIPE_SEQ_STEP_EN
    logic unused_step;
    assign unused_step = I_STEP;
`endif

    pipe_seq_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .CLK   (CLK),
        .RESET (RESET),
        .en    (advance),
        .count (O_CYCLE_COUNT)
    );

    assign O_STATE = state_reg;
    assign O_DONE  = done_reg;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_pipeline_sequencer;

    localparam int DC = 3;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic run = 0, step = 0, halt = 0, lu = 0, br = 0;

    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
    logic [2:0]  state;
    logic        done;
    logic [31:0] count;

    logic        pc_en4, if_id_en4, id_ex_en4, ex_mem_en4, mem_wb_en4, if_id_flush4, id_ex_flush4;
    logic [2:0]  state4;
    logic        done4;
    logic [3:0]  count4;

    always #5 CLK = ~CLK;

    pipeline_sequencer #(.DRAIN_CYCLES(DC), .CNT_W(32)) dut (
        .CLK(CLK), .RESET(RESET), .I_RUN(run), .I_STEP(step), .I_HALT_DECODED(halt),
        .I_LOAD_USE(lu), .I_BRANCH_TAKEN(br),
        .O_PC_EN(pc_en), .O_IF_ID_EN(if_id_en), .O_ID_EX_EN(id_ex_en),
        .O_EX_MEM_EN(ex_mem_en), .O_MEM_WB_EN(mem_wb_en),
        .O_IF_ID_FLUSH(if_id_flush), .O_ID_EX_FLUSH(id_ex_flush),
        .O_STATE(state), .O_DONE(done), .O_CYCLE_COUNT(count)
    );

    pipeline_sequencer #(.DRAIN_CYCLES(DC), .CNT_W(4)) dut4 (
        .CLK(CLK), .RESET(RESET), .I_RUN(run), .I_STEP(step), .I_HALT_DECODED(halt),
        .I_LOAD_USE(lu), .I_BRANCH_TAKEN(br),
        .O_PC_EN(pc_en4), .O_IF_ID_EN(if_id_en4), .O_ID_EX_EN(id_ex_en4),
        .O_EX_MEM_EN(ex_mem_en4), .O_MEM_WB_EN(mem_wb_en4),
        .O_IF_ID_FLUSH(if_id_flush4), .O_ID_EX_FLUSH(id_ex_flush4),
        .O_STATE(state4), .O_DONE(done4), .O_CYCLE_COUNT(count4)
    );

    int checks = 0;
    int failures = 0;

`ifdef PIPE_SEQ_STEP_EN
    bit step_en = 1'b1;
`else
    bit step_en = 1'b0;
`endif

    // Model: mode uses the documented state numbers; left = drain cycles still to go.
    int          m_mode = 0;
    int          m_left = 0;
    logic [31:0] m_count = '0;
    bit          m_done = 1'b0;

    // Enable/flush vector order: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
    function automatic logic [6:0] obs_en();
        return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};
    endfunction

    function automatic logic [6:0] exp_en();
        if (m_mode == 1 || m_mode == 2) begin
            if (br)      return 7'b1111111;
            else if (lu) return 7'b0011101;
            else         return 7'b1111100;
        end
        if (m_mode == 3) return 7'b0011101;
        return 7'b0000000;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_count = '0; m_done = 1'b0;
    endtask

    task automatic model_next();
        case (m_mode)
            0: begin
                if (run) m_mode = 1;
                else if (step && step_en) m_mode = 2;
            end
            1, 2: begin
                m_count = m_count + 1;
                if (!br && !lu && halt) begin
                    m_mode = 3;
                    m_left = DC;
                end else if (m_mode == 2) begin
                    m_mode = 0;
                end
            end
            3: begin
                m_count = m_count + 1;
                m_left  = m_left - 1;
                if (m_left == 0) begin
                    m_mode = 4;
                    m_done = 1'b1;
                end
            end
            default: ;
        endcase
    endtask

    // Advance one clock: model consumes the current inputs, then pulses clear.
    task automatic tick();
        model_next();
        @(posedge CLK);
        #1;
        run = 0; step = 0; halt = 0; lu = 0; br = 0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        #1;
        model_reset();
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; run = 1; halt = 1;
        #1;
        model_reset();
        checks++; if (obs_en() !== 7'b0) begin failures++; $display("FAIL reset_en got=%b exp=0000000", obs_en()); end
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (count !== 32'd0 || count4 !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d/%0d exp=0", count, count4); end
        @(posedge CLK); #1;
        RESET = 1'b0; run = 0; halt = 0;
        for (int i = 0; i < 3; i++) begin
            lu = 1; br = (i == 1);
            #1;
            checks++; if (obs_en() !== 7'b0 || state !== 3'd0 || count !== 32'd0) begin
                failures++; $display("FAIL idle_quiet cycle=%0d en=%b state=%0d count=%0d exp=0", i, obs_en(), state, count);
            end
            tick();
        end
        $display("test_reset done checks=%0d", checks);
    endtask

    task automatic test_run();
        do_reset();
        run = 1;
        #1;
        checks++; if (obs_en() !== 7'b0) begin failures++; $display("FAIL run_cmd_cycle en got=%b exp=0000000", obs_en()); end
        tick();
        for (int i = 0; i < 8; i++) begin
            if (i == 3) step = 1;
            if (i == 5) run = 1;
            #1;
            checks++; if (state !== 3'd1 || obs_en() !== 7'b1111100) begin
                failures++; $display("FAIL run_adv cycle=%0d state=%0d en=%b exp=1/1111100", i, state, obs_en());
            end
            checks++; if (count !== 32'(i)) begin failures++; $display("FAIL run_count cycle=%0d got=%0d exp=%0d", i, count, i); end
            tick();
        end
        $display("test_run done checks=%0d", checks);
    endtask

    task automatic test_load_use();
        lu = 1; halt = 1;
        #1;
        checks++; if (obs_en() !== 7'b0011101) begin failures++; $display("FAIL load_use_en got=%b exp=0011101", obs_en()); end
        tick();
        #1;
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL load_use_state got=%0d exp=1", state); end
        checks++; if (count !== m_count) begin failures++; $display("FAIL load_use_count got=%0d exp=%0d", count, m_count); end
        $display("test_load_use done checks=%0d", checks);
    endtask

    task automatic test_branch();
        br = 1; lu = 1; halt = 1;
        #1;
        checks++; if (obs_en() !== 7'b1111111) begin failures++; $display("FAIL branch_en got=%b exp=1111111", obs_en()); end
        tick();
        #1;
        checks++; if (state !== 3'd1) begin failures++; $display("FAIL branch_state got=%0d exp=1", state); end
        $display("test_branch done checks=%0d", checks);
    endtask

    task automatic test_halt();
        do_reset();
        run = 1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        halt = 1;
        #1;
        checks++; if (count !== 32'd10 || obs_en() !== 7'b1111100) begin
            failures++; $display("FAIL halt_cycle count=%0d en=%b exp=10/1111100", count, obs_en());
        end
        tick();
        for (int d = 0; d < DC; d++) begin
            run = (d == 0); br = (d == 1); lu = (d == 2); step = (d == 0);
            #1;
            checks++; if (state !== 3'd3 || obs_en() !== 7'b0011101 || done !== 1'b0) begin
                failures++; $display("FAIL drain cycle=%0d state=%0d en=%b done=%b exp=3/0011101/0", d, state, obs_en(), done);
            end
            tick();
        end
        checks++; if (state !== 3'd4 || done !== 1'b1 || count !== 32'd14 || obs_en() !== 7'b0) begin
            failures++; $display("FAIL halt_done state=%0d done=%b count=%0d en=%b exp=4/1/14/0000000", state, done, count, obs_en());
        end
        run = 1; step = 1;
        tick();
        tick();
        checks++; if (state !== 3'd4 || count !== 32'd14 || done !== 1'b1) begin
            failures++; $display("FAIL done_sticky state=%0d count=%0d done=%b exp=4/14/1", state, count, done);
        end
        $display("test_halt done checks=%0d", checks);
    endtask

    task automatic test_step();
        logic [6:0] pulse_exp;
        int pulses;
        pulses = 0;
        pulse_exp = step_en ? 7'b1111100 : 7'b0000000;
        do_reset();
        for (int p = 0; p < 3; p++) begin
            step = 1;
            #1;
            checks++; if (obs_en() !== 7'b0) begin failures++; $display("FAIL step_cmd p=%0d en=%b exp=0000000", p, obs_en()); end
            tick();
            checks++; if (obs_en() !== pulse_exp || state !== (step_en ? 3'd2 : 3'd0)) begin
                failures++; $display("FAIL step_pulse p=%0d en=%b state=%0d exp=%b", p, obs_en(), state, pulse_exp);
            end
            for (int k = 0; k < 3; k++) begin
                tick();
                if (obs_en() !== 7'b0) pulses++;
            end
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL step_extra got=%0d exp=0", pulses); end
        checks++; if (count !== (step_en ? 32'd3 : 32'd0)) begin
            failures++; $display("FAIL step_count got=%0d exp=%0d", count, step_en ? 3 : 0);
        end
        $display("test_step done checks=%0d", checks);
    endtask

    task automatic test_wrap();
        do_reset();
        run = 1;
        tick();
        for (int i = 0; i < 17; i++) tick();
        checks++; if (count4 !== 4'd1) begin failures++; $display("FAIL wrap4 got=%0d exp=1", count4); end
        checks++; if (count !== 32'd17) begin failures++; $display("FAIL wrap32 got=%0d exp=17", count); end
        $display("test_wrap done checks=%0d", checks);
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        run = 1;
        tick();
        tick();
        halt = 1;
        tick();
        tick();
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL pre_reset_state got=%0d exp=3", state); end
        RESET = 1'b1;
        #1;
        checks++; if (state !== 3'd0 || count !== 32'd0 || done !== 1'b0 || obs_en() !== 7'b0) begin
            failures++; $display("FAIL mid_drain_reset state=%0d count=%0d done=%b en=%b exp=0", state, count, done, obs_en());
        end
        model_reset();
        @(posedge CLK); #1;
        RESET = 1'b0;
        run = 1;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (state !== 3'd1 || count !== 32'(i)) begin
                failures++; $display("FAIL post_reset_run cycle=%0d state=%0d count=%0d exp=1/%0d", i, state, count, i);
            end
            tick();
        end
        $display("test_reset_mid_drain done checks=%0d", checks);
    endtask

    task automatic test_random();
        int fails_before;
        fails_before = failures;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 79) == 0 || (m_mode == 4 && $urandom_range(0, 7) == 0)) begin
                do_reset();
            end
            run  = ($urandom_range(0, 7) == 0);
            step = ($urandom_range(0, 5) == 0);
            halt = ($urandom_range(0, 11) == 0);
            lu   = ($urandom_range(0, 5) == 0);
            br   = ($urandom_range(0, 7) == 0);
            #1;
            checks++; if (obs_en() !== exp_en()) begin failures++; $display("FAIL rnd_en cycle=%0d got=%b exp=%b", c, obs_en(), exp_en()); end
            checks++; if (state !== 3'(m_mode) || done !== m_done) begin
                failures++; $display("FAIL rnd_state cycle=%0d state=%0d done=%b exp=%0d/%b", c, state, done, m_mode, m_done);
            end
            checks++; if (count !== m_count || count4 !== m_count[3:0]) begin
                failures++; $display("FAIL rnd_count cycle=%0d got=%0d/%0d exp=%0d", c, count, count4, m_count);
            end
            tick();
        end
        $display("test_random done checks=%0d new_failures=%0d", checks, failures - fails_before);
    endtask

    initial begin
        test_reset();
        test_run();
        test_load_use();
        test_branch();
        test_halt();
        test_step();
        test_wrap();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
